pipe_pattern_gen: RTL and testbench



---
 rtl/pipe_pattern_gen_pkg.sv | 26 ++
 rtl/pipe_pattern_gen_lfsr8.sv | 24 ++
 rtl/pipe_pattern_gen.sv | 104 ++++++++++
 tb/tb_pipe_pattern_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pattern_gen_pkg.sv
// Shared types and defaults for the scrolling pipe column generator.
package pipe_pattern_gen_pkg;

  typedef enum logic {
    SPACE = 1'b0,
    PIPE  = 1'b1
  } state_t;

  localparam int         DEF_ROWS       = 30;
  localparam int         DEF_SPACING    = 12;
  localparam int         DEF_PIPE_WIDTH = 4;
  localparam int         DEF_GAP_ROWS   = 8;
  localparam logic [7:0] DEF_SEED       = 8'hA5;

  // Feedback taps for bits 7,5,4,3 of the 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Folds the low five LFSR bits into 0..18 and offsets by 2, so gap_top is 2..20.
  function automatic logic [4:0] gap_from_lfsr(input logic [7:0] v);
    logic [4:0] r;
    r = v[4:0];
    if (r > 5'd18) r = r - 5'd19;
    return r + 5'd2;
  endfunction

endpackage

// File: rtl/pipe_pattern_gen_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when step is high.
module lfsr8
  import pipe_pattern_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_d;

  assign value_d = {value[6:0], ^(value & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= seed;
    end else if (step) begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/pipe_pattern_gen.sv
// Emits one column per frame tick: SPACING empty columns, then PIPE_WIDTH
// identical pipe columns with a pseudo-random GAP_ROWS-high opening.
module pipe_pattern_gen
  import pipe_pattern_gen_pkg::*;
#(
  parameter int         ROWS       = DEF_ROWS,
  parameter int         SPACING    = DEF_SPACING,
  parameter int         PIPE_WIDTH = DEF_PIPE_WIDTH,
  parameter int         GAP_ROWS   = DEF_GAP_ROWS,
  parameter logic [7:0] SEED       = DEF_SEED
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_tick,
  input  logic            enable,
  output logic [ROWS-1:0] column,
  output logic            column_valid,
  output logic [7:0]      pipes_emitted
);

  localparam int SP_W = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int WD_W = (PIPE_WIDTH > 1) ? $clog2(PIPE_WIDTH) : 1;

  state_t          state_q;
  logic [SP_W-1:0] space_cnt_q;
  logic [WD_W-1:0] width_cnt_q;
  logic [4:0]      gap_top_q;
  logic [4:0]      gap_top_d;
  logic [7:0]      lfsr_value;
  logic            accept;
  logic            space_last;
  logic            width_last;
  logic            lfsr_step;
  logic [31:0]     gap_lo;
  logic [31:0]     gap_hi;
  logic [ROWS-1:0] pipe_col;

  assign accept     = frame_tick & enable;
  assign space_last = (space_cnt_q == SP_W'(SPACING - 1));
  assign width_last = (width_cnt_q == WD_W'(PIPE_WIDTH - 1));
  assign lfsr_step  = accept && (state_q == SPACE) && space_last;
  assign gap_top_d  = gap_from_lfsr(lfsr_value);

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .seed  (SEED),
    .value (lfsr_value)
  );

  // Solid everywhere except the GAP_ROWS rows starting at gap_top.
  assign gap_lo = {27'd0, gap_top_q};
  assign gap_hi = gap_lo + 32'(GAP_ROWS);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign pipe_col[gi] = !(($unsigned(gi) >= gap_lo) && ($unsigned(gi) < gap_hi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SPACE;
      space_cnt_q   <= '0;
      width_cnt_q   <= '0;
      gap_top_q     <= '0;
      column        <= '0;
      column_valid  <= 1'b0;
      pipes_emitted <= '0;
    end else begin
      column_valid <= frame_tick;
      if (frame_tick) begin
        column <= '0;
        if (enable) begin
          case (state_q)
            SPACE: begin
              if (space_last) begin
                space_cnt_q <= '0;
                gap_top_q   <= gap_top_d;
                state_q     <= PIPE;
              end else begin
                space_cnt_q <= space_cnt_q + 1'b1;
              end
            end
            PIPE: begin
              column <= pipe_col;
              if (width_last) begin
                width_cnt_q <= '0;
                if (pipes_emitted != 8'hFF) pipes_emitted <= pipes_emitted + 8'd1;
                state_q <= SPACE;
              end else begin
                width_cnt_q <= width_cnt_q + 1'b1;
              end
            end
            default: state_q <= SPACE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_pattern_gen.sv
// Directed bench for pipe_pattern_gen with a per-tick reference model.
module tb_pipe_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic [29:0] column;
  logic        column_valid;
  logic [7:0]  pipes_emitted;

  int checks = 0;
  int failures = 0;

  // reference model state
  int       m_state, m_sp, m_w, m_gap, m_pe;
  bit [7:0] m_lfsr;

  always #5 clk = ~clk;

  pipe_pattern_gen dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .column        (column),
    .column_valid  (column_valid),
    .pipes_emitted (pipes_emitted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] mask_for(input int g);
    logic [29:0] m;
    for (int i = 0; i < 30; i++) m[i] = !((i >= g) && (i < g + 8));
    return m;
  endfunction

  function automatic int gap_of(input bit [7:0] l);
    int r;
    r = int'(l[4:0]);
    if (r > 18) r = r - 19;
    return 2 + r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_sp = 0; m_w = 0; m_gap = 0; m_pe = 0; m_lfsr = 8'hA5;
  endtask

  // Drives one accepted tick (frame_tick left high so back-to-back calls form a held strobe).
  task automatic tick(input bit en, output logic [29:0] obs);
    logic [29:0] exp_col;
    exp_col = '0;
    if (en) begin
      if (m_state == 0) begin
        if (m_sp == 11) begin
          m_sp = 0;
          m_gap = gap_of(m_lfsr);
          m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
          m_state = 1;
        end else m_sp++;
      end else begin
        exp_col = mask_for(m_gap);
        if (m_w == 3) begin
          m_w = 0;
          if (m_pe < 255) m_pe++;
          m_state = 0;
        end else m_w++;
      end
    end
    frame_tick = 1'b1;
    enable = en;
    @(posedge clk);
    #1;
    obs = column;
    check_val("model_column", {2'b0, column}, {2'b0, exp_col});
    check_val("tick_valid", {31'd0, column_valid}, 32'd1);
    check_val("model_pipes", {24'd0, pipes_emitted}, m_pe);
  endtask

  task automatic idle();
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_valid", {31'd0, column_valid}, 32'd0);
  endtask

  initial begin
    logic [29:0] obs;
    int g;

    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_column", {2'b0, column}, 32'd0);
    check_val("rst_valid", {31'd0, column_valid}, 32'd0);
    check_val("rst_pipes", {24'd0, pipes_emitted}, 32'd0);
    reset = 1'b0;
    idle();

    // 12 held-high ticks of space, then the first pipe with gap_top=7
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, obs);
      check_val("space1_zero", {2'b0, obs}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, obs);
      check_val("pipe1_col", {2'b0, obs}, 32'h3FFF807F);
      idle();
    end

    for (int i = 0; i < 12; i++) begin
      tick(1'b1, obs);
      check_val("space2_zero", {2'b0, obs}, 32'd0);
    end
    check_val("pipes_after1", {24'd0, pipes_emitted}, 32'd1);
    idle();

    // second pipe: gap_top=12, paused for 5 ticks after its first column
    tick(1'b1, obs);
    check_val("pipe2_col0", {2'b0, obs}, 32'h3FF00FFF);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, obs);
      check_val("pause_zero", {2'b0, obs}, 32'd0);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, obs);
      check_val("pipe2_resume", {2'b0, obs}, 32'h3FF00FFF);
    end
    idle();
    check_val("pipes_after2", {24'd0, pipes_emitted}, 32'd2);

    // reset coincident with a tick in the middle of the third pipe
    for (int i = 0; i < 14; i++) tick(1'b1, obs);
    reset = 1'b1;
    frame_tick = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_tick_valid", {31'd0, column_valid}, 32'd0);
    check_val("rst_tick_pipes", {24'd0, pipes_emitted}, 32'd0);
    check_val("rst_tick_column", {2'b0, column}, 32'd0);
    reset = 1'b0;
    model_reset();
    idle();
    for (int i = 0; i < 12; i++) tick(1'b1, obs);
    tick(1'b1, obs);
    check_val("post_rst_gap7", {2'b0, obs}, 32'h3FFF807F);
    for (int i = 0; i < 3; i++) tick(1'b1, obs);

    // long run: saturation and gap range
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < 16; i++) begin
        tick(1'b1, obs);
        if (obs != '0) begin
          g = 0;
          while (g < 30 && obs[g]) g++;
          check_val("gap_range", {31'd0, (g >= 2 && g <= 20)}, 32'd1);
        end
      end
    end
    idle();
    check_val("pipes_saturated", {24'd0, pipes_emitted}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
